mod_down_timer: RTL and testbench
=================================

Name: mod_down_timer

Overview:
- Programmable modulo down-counter/timer. It is the count-down counterpart to the team's mod-10 up counter.
- Loads a reload value through a valid/ready handshake, counts down to 0 on enabled cycles, and flags terminal count.
- Supports one-shot and auto-reload modes.
- Used as a tick/period generator and event timer beside the existing up counters.

Parameters:
- N, 4, counter and reload width in bits.
- MOD_DEFAULT, 9, reload value after reset. Must fit in N bits; the default period is 10 enabled cycles.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset_n  input  1  active-low, asynchronous reset.
- enable  input  1  count enable; Q holds while low.
- start  input  1  one-cycle request to begin counting.
- stop  input  1  one-cycle request to abort counting.
- auto_reload  input  1  1 = periodic, 0 = one-shot. Sampled at the terminal-count edge.
- load_valid  input  1  reload value offered.
- load_value  input  N  new reload value; full range 0..2^N-1.
- load_ready  output  1  reload value can be accepted this cycle.
- Q  output  N  current count.
- tc  output  1  registered terminal-count pulse.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values (immediate, including mid-count):
  - state = IDLE; Q = MOD_DEFAULT; reload_reg = MOD_DEFAULT.
  - tc = 0, busy = 0, done = 0, load_ready = 1.
- States:
  - IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
  - load_ready = (state != RUN), driven combinationally from state.
- Load handshake:
  - Transfer occurs when load_valid && load_ready.
  - At that edge: reload_reg <= load_value and Q <= load_value.
  - In RUN, load_ready = 0; load_valid is ignored and the master must hold it.
- IDLE/DONE + start:
  - Next state RUN; Q <= reload_reg.
  - If a load transfers in the same cycle, Q <= load_value instead.
  - DONE -> RUN clears done.
- start while in RUN is ignored.
- RUN, enable=1, stop=0:
  - If Q != 0: Q <= Q-1.
  - If Q == 0: tc <= 1 for exactly the next cycle. Then:
    - auto_reload=1: Q <= reload_reg, stay RUN.
    - auto_reload=0: state <= DONE, Q stays 0.
- RUN, enable=0: Q holds, no tc; stop is still honoured.
- Stop:
  - stop in RUN has priority over counting: state <= IDLE, Q <= reload_reg, no tc.
  - stop in IDLE/DONE has no effect.
  - start and stop in the same cycle: stop wins in RUN; start wins in IDLE/DONE.
- Period:
  - Period is reload_reg+1 enabled cycles.
  - reload 0 with auto_reload gives tc after every enabled edge. This is continuous high while enable is held, which is legal.
- tc is low in every cycle not directly following a terminal-count edge.
- Arithmetic:
  - Plain N-bit decrement.
  - Underflow never occurs because zero is detected before decrementing.
  - No saturation at 2^N-1 is needed.

Decomposition:
- Shared header/package mod_counter_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 illegal, recovers to IDLE);
  - the shared default-modulus constant.
- One natural sub-module, mod_down_counter_core: Q register, reload_reg, decrement, zero detect, load mux.
- Top level holds the FSM, handshake and tc/done flags.

Test Plan (N=4, MOD_DEFAULT=9):
1. Reset, then start, enable=1 constantly, auto_reload=1 -> Q runs 9,8,...,0,9; tc high exactly one cycle after each Q==0 edge, every 10 cycles.
2. In IDLE, load_value=3 with load_valid, then start, auto_reload=0 -> Q 3,2,1,0, then DONE; done=1, tc pulses once, Q holds 0, busy=0.
3. In RUN, hold load_valid with 5 -> load_ready=0, Q unaffected. After DONE, load_ready=1, the transfer completes, and Q=5.
4. Toggle enable 1,0,0,1 during RUN from Q=6 -> Q goes 5,5,5,4; no tc.
5. stop at Q=4 in RUN -> next cycle state IDLE, Q=reload_reg (9), no tc. start+load(2) in the same cycle from IDLE -> RUN with Q=2.
6. Assert reset_n=0 mid-count at Q=2 between clock edges -> Q=9, busy=0 and tc=0 immediately, without waiting for a clock edge. Also: reload 0 with auto_reload=1 -> tc high on every enabled cycle.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared state encodings and default modulus for the mod counters
package mod_counter_pkg;

  // Default reload value: a period of 10 enabled cycles.
  localparam int unsigned MOD_DEFAULT_VAL = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    Q_HOLD   = 2'd0,
    Q_DEC    = 2'd1,
    Q_RELOAD = 2'd2
  } q_op_e;

endpackage

// File: rtl/mod_down_counter_core.sv
// rtl/mod_down_counter_core.sv - count register, reload register, decrement and zero detect
module mod_down_counter_core
  import mod_counter_pkg::*;
#(
  parameter int N           = 4,
  parameter int MOD_DEFAULT = int'(MOD_DEFAULT_VAL)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_xfer,
  input  logic [N-1:0] load_value,
  input  q_op_e        q_op,
  output logic [N-1:0] q,
  output logic         q_zero
);

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] reload_q, reload_d;

  // An accepted load overrides every other count update in the same cycle.
  always_comb begin
    reload_d = reload_q;
    q_d      = q_q;
    unique case (q_op)
      Q_DEC:    q_d = q_q - 1'b1;
      Q_RELOAD: q_d = reload_q;
      default:  q_d = q_q;
    endcase
    if (load_xfer) begin
      reload_d = load_value;
      q_d      = load_value;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q      <= N'(MOD_DEFAULT);
      reload_q <= N'(MOD_DEFAULT);
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
    end
  end

  assign q      = q_q;
  assign q_zero = (q_q == '0);

endmodule

// File: rtl/mod_down_timer.sv
// rtl/mod_down_timer.sv - programmable modulo down-timer with one-shot and auto-reload modes
module mod_down_timer
  import mod_counter_pkg::*;
#(
  parameter int N           = 4,
  parameter int MOD_DEFAULT = int'(MOD_DEFAULT_VAL)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  input  logic         load_valid,
  input  logic [N-1:0] load_value,
  output logic         load_ready,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  state_e state_q, state_d;
  logic   tc_q, tc_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  q_op_e  q_op;
  logic   load_xfer;
  logic   q_zero;

  assign load_ready = (state_q != ST_RUN);
  assign load_xfer  = load_valid && load_ready;

  // Stop outranks counting in RUN; start outranks stop when not running.
  always_comb begin
    state_d = state_q;
    tc_d    = 1'b0;
    q_op    = Q_HOLD;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          q_op    = Q_RELOAD;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          q_op    = Q_RELOAD;
        end else if (enable) begin
          if (q_zero) begin
            tc_d = 1'b1;
            if (auto_reload) begin
              q_op = Q_RELOAD;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            q_op = Q_DEC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mod_down_counter_core #(
    .N           (N),
    .MOD_DEFAULT (MOD_DEFAULT)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_xfer  (load_xfer),
    .load_value (load_value),
    .q_op       (q_op),
    .q          (Q),
    .q_zero     (q_zero)
  );

  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mod_down_timer.sv
// tb/tb_mod_down_timer.sv - randomized self-checking bench for mod_down_timer
module tb_mod_down_timer;

  localparam int N    = 4;
  localparam int MODD = 9;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable, start, stop, auto_reload, load_valid;
  logic [N-1:0] load_value;
  logic         load_ready, tc, busy, done;
  logic [N-1:0] Q;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: running/finished flags plus count and reload as integers.
  bit m_running, m_finished, m_tc;
  int m_q, m_reload;

  mod_down_timer #(.N(N), .MOD_DEFAULT(MODD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .load_valid  (load_valid),
    .load_value  (load_value),
    .load_ready  (load_ready),
    .Q           (Q),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Q"},          32'(Q),          32'(m_q));
    chk({tag, ".tc"},         32'(tc),         32'(m_tc));
    chk({tag, ".busy"},       32'(busy),       32'(m_running));
    chk({tag, ".done"},       32'(done),       32'(m_finished));
    chk({tag, ".load_ready"}, 32'(load_ready), 32'(!m_running));
  endtask

  task automatic model_reset();
    m_running  = 0;
    m_finished = 0;
    m_tc       = 0;
    m_q        = MODD;
    m_reload   = MODD;
  endtask

  task automatic model_step(input bit en, input bit st, input bit sp, input bit ar,
                            input bit lv, input int lval);
    bit accept;
    accept = lv && !m_running;
    m_tc   = 0;
    if (!m_running) begin
      if (st) begin
        m_running  = 1;
        m_finished = 0;
        m_q        = m_reload;
      end
    end else if (sp) begin
      m_running = 0;
      m_q       = m_reload;
    end else if (en) begin
      if (m_q == 0) begin
        m_tc = 1;
        if (ar) m_q = m_reload;
        else begin
          m_running  = 0;
          m_finished = 1;
        end
      end else begin
        m_q = m_q - 1;
      end
    end
    if (accept) begin
      m_reload = lval;
      m_q      = lval;
    end
  endtask

  task automatic cycle(input bit en, input bit st, input bit sp, input bit ar,
                       input bit lv, input int lval, input string tag);
    enable      = en;
    start       = st;
    stop        = sp;
    auto_reload = ar;
    load_valid  = lv;
    load_value  = N'(lval);
    model_step(en, st, sp, ar, lv, lval);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset is asserted between edges and checked before any clock edge arrives.
  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 reset_n = 1'b1;
    enable = 0; start = 0; stop = 0; load_valid = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 0; start = 0; stop = 0; auto_reload = 0; load_valid = 0; load_value = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // Periodic run from the default reload.
    cycle(1, 1, 0, 1, 0, 0, "t1_start");
    repeat (24) cycle(1, 0, 0, 1, 0, 0, "t1_run");

    // One-shot from a loaded value.
    cycle(1, 0, 1, 1, 0, 0, "t2_stop");
    cycle(0, 0, 0, 0, 1, 3, "t2_load");
    cycle(1, 1, 0, 0, 0, 0, "t2_start");
    repeat (6) cycle(1, 0, 0, 0, 0, 0, "t2_run");

    // Held load during RUN lands only after DONE.
    cycle(1, 1, 0, 0, 0, 0, "t3_start");
    repeat (6) cycle(1, 0, 0, 0, 1, 5, "t3_hold");
    chk("t3_q_loaded", 32'(Q), 32'd5);

    // Enable gating, then stop and start-with-load.
    cycle(1, 1, 0, 0, 1, 7, "t4_start");
    cycle(1, 0, 0, 0, 0, 0, "t4_en1");
    cycle(0, 0, 0, 0, 0, 0, "t4_en0a");
    cycle(0, 0, 0, 0, 0, 0, "t4_en0b");
    cycle(1, 0, 0, 0, 0, 0, "t4_en1b");
    cycle(1, 0, 0, 0, 0, 0, "t4_en1c");
    cycle(1, 1, 1, 0, 0, 0, "t5_stop");
    cycle(1, 0, 1, 0, 0, 0, "t5_idle_stop");
    cycle(1, 1, 1, 0, 1, 2, "t5_start_load");
    chk("t5_q2", 32'(Q), 32'd2);

    // Asynchronous reset mid-count.
    async_reset("t6_arst");
    @(negedge clk);
    check_all("t6_after");

    // Reload of zero in periodic mode.
    cycle(0, 0, 0, 1, 1, 0, "t6_load0");
    cycle(1, 1, 0, 1, 0, 0, "t6_start0");
    repeat (5) cycle(1, 0, 0, 1, 0, 0, "t6_tc_cont");
    chk("t6_tc_high", 32'(tc), 32'd1);
    cycle(0, 0, 0, 1, 0, 0, "t6_en_low");

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset("rnd_arst");
        @(negedge clk);
        check_all("rnd_arst_after");
      end else begin
        cycle($urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 4) == 0,
              ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
              "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
